osd_hex_multiwriter: RTL and testbench

OSD_HEX_MULTIWRITER -- requirements
Module: osd_hex_multiwriter

---
 rtl/osd_dbg_pkg.sv | 19 +
 rtl/osd_rr_arbiter.sv | 45 ++++
 rtl/osd_hex_multiwriter.sv | 199 +++++++++++++++++++
 tb/tb_osd_hex_multiwriter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_dbg_pkg.sv
// Shared definitions for the OSD hex writer: FSM states, prefix characters
// and the nibble-to-ASCII conversion.
package osd_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic [7:0] PREFIX_ZERO = 8'h30;
  localparam logic [7:0] PREFIX_X    = 8'h78;

  // Digits land on '0'..'9', letters on uppercase 'A'..'F'.
  function automatic logic [7:0] nibToAscii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/osd_rr_arbiter.sv
// Round-robin arbiter: one-hot grant over the pending channels, searching
// from the channel after the last accepted grant.
module osd_rr_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] i_pending,
  input  logic              i_advance,
  output logic [NUM_CH-1:0] o_grant
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_nextPtr;
  int               w_dist;
  int               w_bestDist;

  // The winner is the pending channel closest to the pointer, going upward with wrap.
  always_comb begin
    o_grant    = '0;
    w_nextPtr  = r_ptr;
    w_dist     = 0;
    w_bestDist = NUM_CH;
    for (int j = 0; j < NUM_CH; j++) begin
      w_dist = (j - int'(r_ptr) + NUM_CH) % NUM_CH;
      if (i_pending[j] && (w_dist < w_bestDist)) begin
        w_bestDist = w_dist;
        o_grant    = '0;
        o_grant[j] = 1'b1;
        w_nextPtr  = PTR_W'((j + 1) % NUM_CH);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance && (|i_pending)) begin
      r_ptr <= w_nextPtr;
    end
  end

endmodule

// File: rtl/osd_hex_multiwriter.sv
// Multi-channel hex value writer into an OSD text buffer.
// Define OSD_HEXW_PREFIX_EN to emit a "0x" prefix before the digits.
module osd_hex_multiwriter #(
  parameter int NUM_CH   = 2,
  parameter int VAL_W    = 8,
  parameter int TXT_COLS = 32,
  parameter int ADDR_W   = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*4-1:0]     line,
  input  logic [NUM_CH*5-1:0]     col,
  input  logic [NUM_CH*VAL_W-1:0] value,
  output logic [NUM_CH-1:0]       ack,
  output logic                    busy,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [7:0]              wr_data
);

  import osd_dbg_pkg::*;

  localparam int NDIG = VAL_W / 4;
`ifdef OSD_HEXW_PREFIX_EN
  localparam int PREFIX_LEN = 2;
`else
  localparam int PREFIX_LEN = 0;
`endif
  localparam int LEN   = NDIG + PREFIX_LEN;
  localparam int IDX_W = $clog2(LEN + 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [NUM_CH-1:0]  r_pending;
  logic [3:0]         r_capLine [NUM_CH];
  logic [4:0]         r_capCol  [NUM_CH];
  logic [VAL_W-1:0]   r_capVal  [NUM_CH];
  logic [3:0]         r_actLine;
  logic [4:0]         r_actCol;
  logic [VAL_W-1:0]   r_actVal;
  logic [NUM_CH-1:0]  r_actCh;
  logic [IDX_W-1:0]   r_pos;
  logic [NUM_CH-1:0]  w_grant;
  logic [NUM_CH-1:0]  w_take;
  logic               w_start;
  logic               w_lastChar;
  logic [3:0]         w_selLine;
  logic [4:0]         w_selCol;
  logic [VAL_W-1:0]   w_selVal;
  logic [3:0]         w_emLine;
  logic [4:0]         w_emCol;
  logic [VAL_W-1:0]   w_emVal;
  int                 w_emPos;
  int                 w_colPos;
  logic               w_emEn;
  logic [ADDR_W-1:0]  w_emAddr;
  logic [7:0]         w_emData;

  function automatic logic [7:0] charAt(input logic [VAL_W-1:0] v, input int p);
    logic [VAL_W-1:0] sh;
    int               d;
    d = p - PREFIX_LEN;
`ifdef OSD_HEXW_PREFIX_EN
    if (p == 0) return PREFIX_ZERO;
    if (p == 1) return PREFIX_X;
`endif
    sh = v >> (4 * (NDIG - 1 - d));
    return nibToAscii(sh[3:0]);
  endfunction

  osd_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_pending (r_pending),
    .i_advance (w_start),
    .o_grant   (w_grant)
  );

  assign w_start    = (r_state == IDLE) && (|r_pending);
  assign w_take     = w_start ? w_grant : '0;
  assign w_lastChar = (r_pos == IDX_W'(LEN - 1));

  // A new request re-arms a channel even on the cycle it is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_capLine[i] <= '0;
        r_capCol[i]  <= '0;
        r_capVal[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (req[i]) begin
          r_pending[i] <= 1'b1;
          r_capLine[i] <= line[i*4 +: 4];
          r_capCol[i]  <= col[i*5 +: 5];
          r_capVal[i]  <= value[i*VAL_W +: VAL_W];
        end else if (w_take[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_selLine = '0;
    w_selCol  = '0;
    w_selVal  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        w_selLine = r_capLine[i];
        w_selCol  = r_capCol[i];
        w_selVal  = r_capVal[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (|r_pending) w_nextState = WRITE;
      WRITE:   if (w_lastChar) w_nextState = ACK;
      ACK:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

  // The first character is taken straight from the capture registers so it appears right after grant.
  always_comb begin
    w_emLine = r_actLine;
    w_emCol  = r_actCol;
    w_emVal  = r_actVal;
    w_emPos  = int'(r_pos) + 1;
    if (r_state == IDLE) begin
      w_emLine = w_selLine;
      w_emCol  = w_selCol;
      w_emVal  = w_selVal;
      w_emPos  = 0;
    end
    w_colPos = int'(w_emCol) + w_emPos;
    w_emEn   = (w_colPos < TXT_COLS);
    w_emAddr = ADDR_W'(int'(w_emLine) * TXT_COLS + w_colPos);
    w_emData = charAt(w_emVal, w_emPos);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_actLine <= '0;
      r_actCol  <= '0;
      r_actVal  <= '0;
      r_actCh   <= '0;
      r_pos     <= '0;
      ack       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      ack   <= '0;
      wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_actLine <= w_selLine;
            r_actCol  <= w_selCol;
            r_actVal  <= w_selVal;
            r_actCh   <= w_grant;
            r_pos     <= '0;
            wr_en     <= w_emEn;
            wr_addr   <= w_emAddr;
            wr_data   <= w_emData;
          end
        end
        WRITE: begin
          if (w_lastChar) begin
            ack <= r_actCh;
          end else begin
            r_pos   <= r_pos + IDX_W'(1);
            wr_en   <= w_emEn;
            wr_addr <= w_emAddr;
            wr_data <= w_emData;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_hex_multiwriter.sv
// Scoreboard bench for osd_hex_multiwriter: a transaction-level model predicts
// every buffer write and ack with its cycle; a monitor compares what the DUT shows.
module tb_osd_hex_multiwriter;

  localparam int NUM_CH   = 2;
  localparam int VAL_W    = 8;
  localparam int TXT_COLS = 32;
  localparam int ADDR_W   = 7;
  localparam int NDIG     = VAL_W / 4;
`ifdef OSD_HEXW_PREFIX_EN
  localparam int LEN = NDIG + 2;
`else
  localparam int LEN = NDIG;
`endif

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wrExp_t;

  typedef struct {
    int cyc;
    int ch;
  } ackExp_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH*4-1:0]     line;
  logic [NUM_CH*5-1:0]     col;
  logic [NUM_CH*VAL_W-1:0] value;
  logic [NUM_CH-1:0]       ack;
  logic                    busy;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [7:0]              wr_data;

  int total = 0;
  int bad   = 0;
  int edgeNo = 0;

  bit               mPend [NUM_CH];
  logic [3:0]       mLine [NUM_CH];
  logic [4:0]       mCol  [NUM_CH];
  logic [VAL_W-1:0] mVal  [NUM_CH];
  int               mPtr = 0;
  int               nextFree = 0;
  int               busyFirst = 0;
  int               busyLast = -1;
  wrExp_t           wrQ [$];
  ackExp_t          ackQ [$];

  always #5 clk = ~clk;

  osd_hex_multiwriter #(
    .NUM_CH   (NUM_CH),
    .VAL_W    (VAL_W),
    .TXT_COLS (TXT_COLS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .line    (line),
    .col     (col),
    .value   (value),
    .ack     (ack),
    .busy    (busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The text the model expects: uppercase hex, optional "0x" in front.
  function automatic string expStr(input logic [VAL_W-1:0] v);
    string s;
    s = $sformatf("%h", v);
    s = s.toupper();
`ifdef OSD_HEXW_PREFIX_EN
    s = {"0x", s};
`endif
    return s;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NUM_CH; i++) mPend[i] = 1'b0;
    mPtr      = 0;
    nextFree  = 0;
    busyFirst = 0;
    busyLast  = -1;
    wrQ.delete();
    ackQ.delete();
  endfunction

  function automatic void grantOne();
    int    ch;
    int    g;
    int    c;
    string s;
    ch = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch < 0 && mPend[(mPtr + k) % NUM_CH]) ch = (mPtr + k) % NUM_CH;
    end
    if (ch < 0) return;
    g = edgeNo;
    s = expStr(mVal[ch]);
    for (int p = 0; p < LEN; p++) begin
      c = int'(mCol[ch]) + p;
      if (c < TXT_COLS)
        wrQ.push_back('{g + p, (int'(mLine[ch]) * TXT_COLS + c) % (1 << ADDR_W), int'(s[p])});
    end
    ackQ.push_back('{g + LEN, ch});
    busyFirst = g;
    busyLast  = g + LEN;
    nextFree  = g + LEN + 2;
    mPend[ch] = 1'b0;
    mPtr      = (ch + 1) % NUM_CH;
  endfunction

  // Reference model: grant decision sees pending state from before this edge's requests.
  always @(posedge clk) begin
    edgeNo++;
    if (!rst_n) begin
      modelReset();
    end else begin
      if (edgeNo >= nextFree) grantOne();
      for (int i = 0; i < NUM_CH; i++) begin
        if (req[i]) begin
          mPend[i] = 1'b1;
          mLine[i] = line[i*4 +: 4];
          mCol[i]  = col[i*5 +: 5];
          mVal[i]  = value[i*VAL_W +: VAL_W];
        end
      end
    end
  end

  // Monitor: pop expectations whenever the DUT shows a write or ack, or when one is overdue.
  always @(negedge clk) begin
    wrExp_t  w;
    ackExp_t a;
    if (rst_n) begin
      checkOutput("busy", int'(busy), int'(edgeNo >= busyFirst && edgeNo <= busyLast));
      if (wr_en) begin
        if (wrQ.size() == 0) begin
          checkOutput("unexpected_write", 1, 0);
        end else begin
          w = wrQ.pop_front();
          checkOutput("write_cycle", edgeNo, w.cyc);
          checkOutput("wr_addr", int'(wr_addr), w.addr);
          checkOutput("wr_data", int'(wr_data), w.data);
        end
      end else if (wrQ.size() > 0 && wrQ[0].cyc <= edgeNo) begin
        w = wrQ.pop_front();
        checkOutput("missed_write", 0, 1);
      end
      if (ack != '0) begin
        if (ackQ.size() == 0) begin
          checkOutput("unexpected_ack", int'(ack), 0);
        end else begin
          a = ackQ.pop_front();
          checkOutput("ack_cycle", edgeNo, a.cyc);
          checkOutput("ack_vec", int'(ack), 1 << a.ch);
        end
      end else if (ackQ.size() > 0 && ackQ[0].cyc <= edgeNo) begin
        a = ackQ.pop_front();
        checkOutput("missed_ack", 0, 1 << a.ch);
      end
    end
  end

  task automatic loadChannel(input int ch, input int l, input int c, input int v);
    line[ch*4 +: 4]          = 4'(l);
    col[ch*5 +: 5]           = 5'(c);
    value[ch*VAL_W +: VAL_W] = VAL_W'(v);
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] r);
    @(negedge clk);
    req = r;
    @(negedge clk);
    req = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    line  = '0;
    col   = '0;
    value = '0;
    idle(3);
    checkOutput("reset_wr_en", int'(wr_en), 0);
    checkOutput("reset_wr_addr", int'(wr_addr), 0);
    checkOutput("reset_wr_data", int'(wr_data), 0);
    checkOutput("reset_ack", int'(ack), 0);
    checkOutput("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle(2);

    $display("[TB] single request, line 1 col 8 value 3C");
    loadChannel(0, 1, 8, 'h3C);
    applyStimulus(2'b01);
    idle(8);

    $display("[TB] simultaneous requests on both channels");
    loadChannel(0, 2, 0, 'h5A);
    loadChannel(1, 3, 4, 'hE7);
    applyStimulus(2'b11);
    idle(14);

    $display("[TB] re-request of channel 1 during its own write");
    loadChannel(1, 0, 16, 'h10);
    applyStimulus(2'b10);
    loadChannel(1, 0, 16, 'hFF);
    applyStimulus(2'b10);
    idle(14);

    $display("[TB] right-edge columns and address truncation");
    loadChannel(0, 5, 31, 'h9B);
    applyStimulus(2'b01);
    idle(8);
    loadChannel(1, 15, 30, 'hD2);
    applyStimulus(2'b10);
    idle(8);

    $display("[TB] reset in the second write cycle");
    loadChannel(0, 4, 2, 'hC4);
    applyStimulus(2'b01);
    idle(2);
    #1 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset_wr_en", int'(wr_en), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_ack", int'(ack), 0);
    idle(2);
    rst_n = 1'b1;
    loadChannel(1, 6, 6, 'h7D);
    applyStimulus(2'b10);
    idle(10);

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) begin
        req[i] = ($urandom_range(0, 7) == 0);
        if (req[i])
          loadChannel(i, int'($urandom_range(0, 15)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(28, 31))
                                                  : int'($urandom_range(0, 31)),
                      int'($urandom));
      end
    end
    @(negedge clk);
    req = '0;
    idle(30);

    checkOutput("writes_left", wrQ.size(), 0);
    checkOutput("acks_left", ackQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
